// File: rtl/priority_encoder_8x3_seq_if.sv
// priority_encoder_8x3_seq_if: request/index handshake bundle for the 8x3 priority encoder
//   e       enable, 1 = new indices may be issued
//   req     8 request pulses, bit k = request k
//   y       offered 3-bit index
//   valid   y holds a valid index
//   ready   consumer accepts y when valid && ready
//   pending sticky pending requests
//   ovf     one-cycle pulse when a request hit an already pending bit
interface priority_encoder_8x3_seq_if;
    logic       e;
    logic [7:0] req;
    logic [2:0] y;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       ovf;
    modport master (output e, req, ready, input y, valid, pending, ovf);
    modport slave (input e, req, ready, output y, valid, pending, ovf);
endinterface

// File: rtl/priority_encoder_8x3_seq.sv
// priority_encoder_8x3_seq: registered 8-to-3 priority encoder with sticky pending requests and valid/ready output
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of priority_encoder_8x3_seq_if (e, req, ready in; y, valid, pending, ovf out)
//   PRIO_ROUND_ROBIN_EN defined: rotating priority starting below the last served index;
//   undefined: fixed priority, bit 7 highest.
module priority_encoder_8x3_seq (
    input logic clk,
    input logic rst_n,
    priority_encoder_8x3_seq_if.slave bus
);
    logic [7:0] pending_q, pending_d, clear_mask;
    logic [2:0] y_q, y_d, g;
    logic       valid_q, valid_d, ovf_q, ovf_d, slot_free, issue;
`ifdef PRIO_ROUND_ROBIN_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;
    // Scan rr_ptr-1 downward with wrap; the last assignment is the first hit of the scan.
    always_comb begin
        g = 3'd0;
        for (int k = 8; k >= 1; k--)
            if (pending_q[3'(rr_ptr_q - 3'(k))]) g = 3'(rr_ptr_q - 3'(k));
    end
    assign rr_ptr_d = issue ? g : rr_ptr_q;
`else
    always_comb begin
        g = 3'd0;
        for (int k = 0; k < 8; k++)
            if (pending_q[k]) g = 3'(k);
    end
`endif
    always_comb begin
        slot_free  = !valid_q || bus.ready;
        issue      = bus.e && slot_free && (pending_q != 8'd0);
        clear_mask = issue ? 8'(8'd1 << g) : 8'd0;
        // A new request on the bit being served survives as a fresh request.
        pending_d  = (pending_q & ~clear_mask) | bus.req;
        ovf_d      = |(bus.req & pending_q & ~clear_mask);
        y_d        = issue ? g : y_q;
        valid_d    = issue ? 1'b1 : (slot_free ? 1'b0 : valid_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 8'd0;
            y_q       <= 3'd0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef PRIO_ROUND_ROBIN_EN
            rr_ptr_q  <= 3'd0;
`endif
        end else begin
            pending_q <= pending_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
`ifdef PRIO_ROUND_ROBIN_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end
    assign bus.pending = pending_q;
    assign bus.y       = y_q;
    assign bus.valid   = valid_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_priority_encoder_8x3_seq.sv
// tb_priority_encoder_8x3_seq: directed and randomized checks of priority_encoder_8x3_seq against a behavioural model
module tb_priority_encoder_8x3_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] m_pend;
    logic [2:0] m_y;
    logic       m_valid, m_ovf;
    int         m_last;
    always #5 clk = ~clk;
    priority_encoder_8x3_seq_if bus ();
    priority_encoder_8x3_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    function automatic int pick(logic [7:0] p, int last);
`ifdef PRIO_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last - k + 16) % 8;
            if (p[i]) return i;
        end
`else
        for (int i = 7; i >= 0; i--)
            if (p[i]) return i;
`endif
        return 0;
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        logic [7:0] n_pend, served;
        logic [2:0] n_y;
        logic       n_valid, n_ovf, iss;
        int         g, n_last;
        if (!rst_n) begin
            n_pend = 0; n_y = 0; n_valid = 0; n_ovf = 0; n_last = 0;
        end else begin
            iss     = bus.e && (!m_valid || bus.ready) && (m_pend != 0);
            g       = pick(m_pend, m_last);
            served  = iss ? 8'(1 << g) : 8'd0;
            n_ovf   = |(bus.req & m_pend & ~served);
            n_pend  = (m_pend & ~served) | bus.req;
            n_y     = iss ? 3'(g) : m_y;
            n_valid = iss ? 1'b1 : ((!m_valid || bus.ready) ? 1'b0 : m_valid);
            n_last  = iss ? g : m_last;
        end
        @(posedge clk);
        #1;
        m_pend = n_pend; m_y = n_y; m_valid = n_valid; m_ovf = n_ovf; m_last = n_last;
        chk("pending", bus.pending, m_pend);
        chk("valid", bus.valid, m_valid);
        chk("y", bus.y, m_y);
        chk("ovf", bus.ovf, m_ovf);
    endtask
    initial begin
        m_pend = 0; m_y = 0; m_valid = 0; m_ovf = 0; m_last = 0;
        rst_n = 1'b0; bus.e = 1'b1; bus.ready = 1'b1; bus.req = 8'hFF;
        cyc(); cyc();
        chk("rst_pending", bus.pending, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1; bus.req = 8'h84;
        cyc();
        chk("t2_pend", bus.pending, 8'h84);
        bus.req = 8'h00;
        cyc();
        chk("t2_y7", {bus.valid, bus.y}, {1'b1, 3'd7});
        cyc();
        chk("t2_y2", {bus.valid, bus.y}, {1'b1, 3'd2});
        cyc();
        chk("t2_idle", {bus.valid, bus.pending}, 9'd0);
        bus.req = 8'h20;
        cyc();
        bus.req = 8'h00; bus.ready = 1'b0;
        cyc();
        chk("t3_y5", {bus.valid, bus.y}, {1'b1, 3'd5});
        for (int i = 0; i < 4; i++) begin
            bus.req = (i == 0) ? 8'h40 : 8'h00;
            cyc();
            chk("t3_hold", {bus.valid, bus.y}, {1'b1, 3'd5});
        end
        chk("t3_pend6", bus.pending, 8'h40);
        bus.ready = 1'b1;
        cyc();
        chk("t3_y6", {bus.valid, bus.y}, {1'b1, 3'd6});
        cyc();
        bus.e = 1'b0; bus.req = 8'h01;
        cyc();
        bus.req = 8'h00;
        cyc();
        chk("t4_pend", {bus.valid, bus.pending}, {1'b0, 8'h01});
        bus.e = 1'b1;
        cyc();
        chk("t4_y0", {bus.valid, bus.y, bus.pending}, {1'b1, 3'd0, 8'h00});
        cyc();
        bus.e = 1'b0; bus.req = 8'h08;
        cyc();
        chk("t5_noovf", bus.ovf, 0);
        cyc();
        chk("t5_ovf", {bus.ovf, bus.pending}, {1'b1, 8'h08});
        bus.req = 8'h00;
        cyc();
        chk("t5_ovf_end", bus.ovf, 0);
        bus.e = 1'b1;
        cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; bus.req = 8'h81;
        cyc();
        cyc();
        chk("t6_first", {bus.valid, bus.y}, {1'b1, 3'd7});
        cyc();
`ifdef PRIO_ROUND_ROBIN_EN
        chk("t6_second", {bus.valid, bus.y}, {1'b1, 3'd0});
`else
        chk("t6_second", {bus.valid, bus.y}, {1'b1, 3'd7});
`endif
        for (int i = 0; i < 6; i++) cyc();
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            bus.e     = ($urandom_range(0, 4) != 0);
            bus.ready = ($urandom_range(0, 2) != 0);
            bus.req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
